// File: rtl/bitty_wb_pipe_pkg.sv
// Shared constants and helpers for the bitty post-EX write-back pipeline.
package bitty_wb_pipe_pkg;

    localparam int   WB_PIPE_DEPTH_MIN = 2;
    localparam int   REG_W             = 32;
    localparam int   REG_ADDR_W        = 5;
    localparam logic WRITE_ENABLE      = 1'b1;
    localparam logic WRITE_DISABLE     = 1'b0;

    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    // Saturating increment for the 32-bit event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bitty_wb_pipe_if.sv
// Bus between the core (EX, memory, decode, regfile) and the write-back pipeline.
interface bitty_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // Flow control: stall_i=1 holds every stage; stall_req_o=1 asks the core to
    // hold EX/decode. No valid/ready pairs: ex_wreg_i marks a live result.
    logic                     stall_i;
    logic                     flush_i;
    logic                     ex_wreg_i;
    logic [ADDR_W-1:0]        ex_wd_i;
    logic [DATA_W-1:0]        ex_wdata_i;
    logic                     ex_pend_i;
    logic                     mem_ld_vld_i;
    logic [DATA_W-1:0]        mem_ld_data_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rf_data_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        hazard_o;
    logic                     stall_req_o;
    logic                     wb_wreg_o;
    logic [ADDR_W-1:0]        wb_wd_o;
    logic [DATA_W-1:0]        wb_wdata_o;

    modport slave (
        input  stall_i, flush_i, ex_wreg_i, ex_wd_i, ex_wdata_i, ex_pend_i,
               mem_ld_vld_i, mem_ld_data_i, rd_addr_i, rf_data_i,
        output rd_data_o, hazard_o, stall_req_o, wb_wreg_o, wb_wd_o, wb_wdata_o
    );

    modport master (
        output stall_i, flush_i, ex_wreg_i, ex_wd_i, ex_wdata_i, ex_pend_i,
               mem_ld_vld_i, mem_ld_data_i, rd_addr_i, rf_data_i,
        input  rd_data_o, hazard_o, stall_req_o, wb_wreg_o, wb_wd_o, wb_wdata_o
    );
endinterface

// File: rtl/bitty_wb_pipe_stage.sv
// One write-back pipeline entry: hold, load, bubble, and load-data resolve.
module bitty_wb_stage
    import bitty_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              bubble,
    input  logic              resolve,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              d_wreg,
    input  logic [ADDR_W-1:0] d_wd,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_pend,
    output logic              q_wreg,
    output logic [ADDR_W-1:0] q_wd,
    output logic [DATA_W-1:0] q_data,
    output logic              q_pend
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wreg <= WRITE_DISABLE;
            q_wd   <= '0;
            q_data <= '0;
            q_pend <= 1'b0;
        end else if (adv) begin
            if (bubble) begin
                q_wreg <= WRITE_DISABLE;
                q_wd   <= '0;
                q_data <= '0;
                q_pend <= 1'b0;
            end else begin
                // A pending load picks up its memory data as it leaves stage 0.
                q_wreg <= d_wreg;
                q_wd   <= d_wd;
                q_data <= resolve ? ld_data : d_data;
                q_pend <= resolve ? 1'b0 : d_pend;
            end
        end
    end

endmodule

// File: rtl/bitty_wb_pipe.sv
// Post-EX result pipeline with priority operand forwarding and load-use hazards.
// Optional macro BITTY_WB_PIPE_PERF_EN adds saturating hazard/forward counters.
module bitty_wb_pipe
    import bitty_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int NUM_RD = 2
) (
    input logic            clk,
    input logic            rst,
    bitty_wb_pipe_if.slave bus
`ifdef BITTY_WB_PIPE_PERF_EN
    ,
    output logic [31:0]    perf_hz_cnt_o,
    output logic [31:0]    perf_fwd_cnt_o
`endif
);

    logic              st_wreg [DEPTH];
    logic [ADDR_W-1:0] st_wd   [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic              st_pend [DEPTH];

    logic ld_wait;
    logic adv;

    assign ld_wait = st_pend[0] && st_wreg[0] && !bus.mem_ld_vld_i;
    assign adv     = !bus.stall_i && !ld_wait;

    for (genvar n = 0; n < DEPTH; n++) begin : g_stage
        logic              d_wreg;
        logic [ADDR_W-1:0] d_wd;
        logic [DATA_W-1:0] d_data;
        logic              d_pend;
        logic              bubble;
        logic              resolve;

        if (n == 0) begin : g_head
            assign d_wreg  = bus.ex_wreg_i;
            assign d_wd    = bus.ex_wd_i;
            assign d_data  = bus.ex_wdata_i;
            assign d_pend  = bus.ex_pend_i;
            assign bubble  = bus.flush_i;
            assign resolve = 1'b0;
        end else begin : g_tail
            assign d_wreg  = st_wreg[n-1];
            assign d_wd    = st_wd[n-1];
            assign d_data  = st_data[n-1];
            assign d_pend  = st_pend[n-1];
            assign bubble  = 1'b0;
            assign resolve = (n == 1) ? st_pend[0] : 1'b0;
        end

        bitty_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .bubble  (bubble),
            .resolve (resolve),
            .ld_data (bus.mem_ld_data_i),
            .d_wreg  (d_wreg),
            .d_wd    (d_wd),
            .d_data  (d_data),
            .d_pend  (d_pend),
            .q_wreg  (st_wreg[n]),
            .q_wd    (st_wd[n]),
            .q_data  (st_data[n]),
            .q_pend  (st_pend[n])
        );
    end

    logic [NUM_RD*DATA_W-1:0] rd_flat;
    logic [NUM_RD-1:0]        hazard;
    logic [NUM_RD-1:0]        fwd_hit;

    // Oldest source first so younger matches overwrite older ones.
    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              hz;
        logic              hit;
        rd_flat = '0;
        hazard  = '0;
        fwd_hit = '0;
        addr    = '0;
        data    = '0;
        hz      = 1'b0;
        hit     = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            addr = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
            data = bus.rf_data_i[p*DATA_W +: DATA_W];
            hz   = 1'b0;
            hit  = 1'b0;
            for (int n = DEPTH - 1; n >= 0; n--) begin
                if (st_wreg[n] && st_wd[n] == addr) begin
                    if (!st_pend[n]) begin
                        data = st_data[n];
                        hz   = 1'b0;
                    end else if (n == 0 && bus.mem_ld_vld_i) begin
                        data = bus.mem_ld_data_i;
                        hz   = 1'b0;
                    end else begin
                        data = '0;
                        hz   = 1'b1;
                    end
                    hit = !hz;
                end
            end
            if (!bus.flush_i && bus.ex_wreg_i && bus.ex_wd_i == addr) begin
                data = bus.ex_pend_i ? '0 : bus.ex_wdata_i;
                hz   = bus.ex_pend_i;
                hit  = !bus.ex_pend_i;
            end
            if (addr == '0) begin
                data = '0;
                hz   = 1'b0;
                hit  = 1'b0;
            end
            rd_flat[p*DATA_W +: DATA_W] = data;
            hazard[p]  = hz;
            fwd_hit[p] = hit;
        end
    end

    assign bus.rd_data_o   = rd_flat;
    assign bus.hazard_o    = hazard;
    assign bus.stall_req_o = (|hazard) || ld_wait;
    assign bus.wb_wreg_o   = st_wreg[DEPTH-1];
    assign bus.wb_wd_o     = st_wd[DEPTH-1];
    assign bus.wb_wdata_o  = st_data[DEPTH-1];

`ifdef BITTY_WB_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hz_cnt_o  <= '0;
            perf_fwd_cnt_o <= '0;
        end else begin
            if (bus.stall_req_o) perf_hz_cnt_o  <= sat_inc(perf_hz_cnt_o);
            if (|fwd_hit)        perf_fwd_cnt_o <= sat_inc(perf_fwd_cnt_o);
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_hit;
`endif

endmodule
